alu_ctrl_pipe: RTL
==================

// Module: alu_ctrl_pipe
// PURPOSE
//  Registered, handshaked ALU-control stage between the main decoder and the ALU.
//  Decodes aluop and funct into an ALU control code, and sequences the multi-beat jmor op.
//  jmorsig is a per-beat registered output and never holds a stale value.
//  Flags undefined R-type funct codes.
// PARAMETERS
//  ALUOP_W    4          aluop width; bit3=mem, bits2:0 = class code
//  FUNCT_W    6          funct width, >=6; only bits 5:0 are decoded, upper bits must be 0
//  CTL_W      3          ALU control width; codes AND=000 OR=001 ADD=010 SLL=011 SUB=110 SLT=111
//  JMOR_FUNCT 6'b100110  funct code of jmor
//  JMOR_BEATS 2          output beats per jmor, range 2..4
// PORTS
//  clk        in  1        rising-edge clock
//  rst_n      in  1        asynchronous, active-low reset
//  in_valid   in  1        aluop/funct valid
//  in_ready   out 1        stage accepts an input this cycle
//  aluop      in  ALUOP_W  class from main decoder
//  funct      in  FUNCT_W  R-type function code
//  out_valid  out 1        gout/jmorsig/illegal/last valid
//  out_ready  in  1        ALU consumes the beat
//  gout       out CTL_W    ALU control
//  jmorsig    out 1        beat belongs to jmor
//  last       out 1        final beat of the instruction
//  illegal    out 1        undefined R-type funct; gout=ADD on that beat
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, gout=010, jmorsig=0, last=0, illegal=0, FSM=IDLE.
//  Deassertion of rst_n is synchronised to clk by the parent.
//  Accept occurs when in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Latency: the first beat is registered and visible the cycle after accept.
//  Throughput is one instruction per cycle with out_ready held high.
//  Hold rule: while out_valid & ~out_ready, every output is held stable.
//  Decode priority, first match wins:
//   aluop[3]=1 -> ADD
//   aluop[2:0]=101 or 001 -> SUB
//   aluop[2:0]=100 -> AND
//   aluop[1]=1 (R-type), matched in this order:
//    funct==JMOR_FUNCT -> jmor sequence
//    funct==000000 -> SLL
//    f2&f0 -> OR
//    f2&~f0 -> AND
//    f1&~f3 -> SUB
//    f1&f3 -> SLT
//    f[3:0]==0000 -> ADD
//    else -> ADD with illegal=1
//   anything else -> ADD
//  Single-beat ops: last=1, jmorsig=0.
//  FSM states: IDLE, JMOR.
//   jmor accept: beat 0 is emitted with gout=OR, jmorsig=1, last=0; state goes IDLE->JMOR; beat counter=1.
//   In JMOR, each out_ready on a valid beat advances the counter.
//   Beats 1..JMOR_BEATS-2 emit gout=OR, jmorsig=1, last=0.
//   Beat JMOR_BEATS-1 emits gout=ADD, jmorsig=1, last=1.
//   Consuming the last beat returns the FSM to IDLE.
//   in_ready=0 for the whole of JMOR, so no new accept overlaps a jmor.
//  The counter width is clog2(JMOR_BEATS). It never wraps past JMOR_BEATS-1.
//  Simultaneous events: in IDLE, consuming beat N and accepting N+1 in the same cycle is legal.
//  After a back-to-back accept, out_valid stays 1 and the outputs update.
//  Reset mid-jmor aborts the sequence. No beat is emitted after reset until a new accept.
//  aluop/funct are sampled only on accept. Changes while not accepted are ignored.
// CONFIGURATION
//  ALUCTL_SHIFT_EN defined: funct 000000 decodes to SLL (011).
//  ALUCTL_SHIFT_EN undefined: funct 000000 decodes to ADD (010), illegal=0.
//   Code 011 is then never produced.
// STRUCTURE
//  Package alu_ctrl_pkg:
//   ALU code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SUB, ALU_SLT)
//   aluop class constants
//   FSM state encoding (ST_IDLE, ST_JMOR)
//  Sub-module alu_ctrl_decode: pure combinational decode of aluop/funct.
//   Outputs: ctl, is_jmor, illegal.
//  The top module holds the FSM, beat counter, handshake and output registers.
// TESTING
//  1. aluop=0010, funct=100000, out_ready=1 -> next cycle: out_valid=1, gout=010, last=1, jmorsig=0.
//  2. aluop=0010, funct=100110, JMOR_BEATS=2 -> beat0 gout=001 jmorsig=1 last=0;
//     beat1 gout=010 jmorsig=1 last=1; in_ready=0 across both beats.
//  3. Back-to-back lw(1000), beq(0001), andi(0100), out_ready=1 -> consecutive beats 010, 110, 000;
//     in_ready stays 1.
//  4. Backpressure: out_ready=0 for 3 cycles after an slt (funct=101010) accept
//     -> gout=111 held; in_ready=0; no accept.
//  5. Reset: rst_n=0 during jmor beat0 -> out_valid=0, jmorsig=0 immediately;
//     after release, no beat until next accept.
//  6. funct=000000 R-type -> gout=011 with ALUCTL_SHIFT_EN, 010 without;
//     funct=000001 -> gout=010, illegal=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control codes, aluop class constants and FSM state encoding
//   Imported by alu_ctrl_decode and alu_ctrl_pipe; no ports.
package alu_ctrl_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_BR2  = 3'b101;
    localparam logic [2:0] OP_ANDI = 3'b100;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_JMOR = 1'b1} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational decode of aluop/funct into an ALU control code
//   aluop   in  class from main decoder (bit3 = mem, bits2:0 = class)
//   funct   in  R-type function code, only bits 5:0 decoded
//   ctl     out ALU control code (OR for the first jmor beat)
//   is_jmor out funct selects the multi-beat jmor sequence
//   illegal out undefined R-type funct (ctl = ADD)
//   ALUCTL_SHIFT_EN defined: funct 000000 decodes to SLL, otherwise to ADD.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 6,
    parameter int CTL_W = 3,
    parameter logic [5:0] JMOR_FUNCT = 6'b100110
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTL_W-1:0]   ctl,
    output logic               is_jmor,
    output logic               illegal
);
`ifdef ALUCTL_SHIFT_EN
    localparam logic [2:0] ZERO_CTL = ALU_SLL;
`else
    localparam logic [2:0] ZERO_CTL = ALU_ADD;
`endif
    logic [5:0] f;
    logic [2:0] c;
    assign f = funct[5:0];
    assign ctl = CTL_W'(c);
    always_comb begin
        c = ALU_ADD;
        is_jmor = 1'b0;
        illegal = 1'b0;
        if (aluop[3]) c = ALU_ADD;
        else if (aluop[2:0] == OP_BR2 || aluop[2:0] == OP_BR) c = ALU_SUB;
        else if (aluop[2:0] == OP_ANDI) c = ALU_AND;
        else if (aluop[1]) begin
            if (f == JMOR_FUNCT) begin
                c = ALU_OR;
                is_jmor = 1'b1;
            end
            else if (f == 6'b000000) c = ZERO_CTL;
            else if (f[2] & f[0]) c = ALU_OR;
            else if (f[2]) c = ALU_AND;
            else if (f[1]) c = f[3] ? ALU_SLT : ALU_SUB;
            else if (f[3:0] == 4'b0000) c = ALU_ADD;
            else illegal = 1'b1;
        end
    end
endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered, handshaked ALU-control stage with multi-beat jmor sequencing
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; aluop/funct sampled on accept
//   out_valid/out_ready output handshake; outputs held while stalled
//   gout                ALU control code
//   jmorsig             beat belongs to a jmor
//   last                final beat of the instruction
//   illegal             undefined R-type funct (gout = ADD)
//   ALUCTL_SHIFT_EN (in alu_ctrl_decode) enables SLL decode of funct 000000.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 6,
    parameter int CTL_W = 3,
    parameter logic [5:0] JMOR_FUNCT = 6'b100110,
    parameter int JMOR_BEATS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTL_W-1:0]   gout,
    output logic               jmorsig,
    output logic               last,
    output logic               illegal
);
    localparam int CNT_W = $clog2(JMOR_BEATS);

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CTL_W-1:0] d_ctl, gout_n;
    logic d_jmor, d_ill, valid_n, jmor_n, last_n, ill_n;
    logic accept, consume, beat_last;

    alu_ctrl_decode #(
        .ALUOP_W(ALUOP_W),
        .FUNCT_W(FUNCT_W),
        .CTL_W(CTL_W),
        .JMOR_FUNCT(JMOR_FUNCT)
    ) u_dec (
        .aluop(aluop),
        .funct(funct),
        .ctl(d_ctl),
        .is_jmor(d_jmor),
        .illegal(d_ill)
    );

    assign in_ready = (state == ST_IDLE) & (~out_valid | out_ready);
    assign accept = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    // cnt indexes the beat to emit once the current one is consumed
    assign beat_last = cnt == CNT_W'(JMOR_BEATS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            out_valid <= 1'b0;
            gout <= CTL_W'(ALU_ADD);
            jmorsig <= 1'b0;
            last <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            out_valid <= valid_n;
            gout <= gout_n;
            jmorsig <= jmor_n;
            last <= last_n;
            illegal <= ill_n;
        end
    end

    always_comb begin
        state_n = state;
        if (accept && d_jmor) state_n = ST_JMOR;
        else if (state == ST_JMOR && consume && last) state_n = ST_IDLE;
    end

    always_comb begin
        valid_n = out_valid;
        gout_n = gout;
        jmor_n = jmorsig;
        last_n = last;
        ill_n = illegal;
        cnt_n = cnt;
        if (accept) begin
            valid_n = 1'b1;
            gout_n = d_ctl;
            jmor_n = d_jmor;
            last_n = ~d_jmor;
            ill_n = d_ill;
            cnt_n = CNT_W'(1);
        end else if (consume && state == ST_JMOR && !last) begin
            gout_n = beat_last ? CTL_W'(ALU_ADD) : CTL_W'(ALU_OR);
            last_n = beat_last;
            cnt_n = beat_last ? cnt : cnt + CNT_W'(1);
        end else if (consume) begin
            valid_n = 1'b0;
            jmor_n = 1'b0;
            last_n = 1'b0;
            ill_n = 1'b0;
        end
    end
endmodule
